// File: rtl/db_irq_queue.sv
// db_irq_queue: doorbell interrupt queue between the SRIO doorbell receive
// engine and the PCIe interrupt logic. Doorbell info words are buffered in a
// first-word-fall-through FIFO, a level interrupt request is raised and held
// until acknowledged, and dropped doorbells set a sticky overflow flag.
// Optional macro DB_IRQ_COALESCE_EN adds a hold-off (coalescing) state that
// delays each request by C_HOLDOFF_CYCLES or until the FIFO fills.
module db_irq_queue #(
  parameter int unsigned C_DEPTH_LOG2     = 4,
  parameter int unsigned C_HOLDOFF_CYCLES = 64
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    db_irq,
  input  logic [15:0]             db_info,
  output logic                    irq_req,
  input  logic                    irq_ack,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [15:0]             rd_data,
  output logic [C_DEPTH_LOG2:0]   count,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int unsigned DEPTH = 1 << C_DEPTH_LOG2;
  localparam logic [C_DEPTH_LOG2:0]   FULL_LVL = {1'b1, {C_DEPTH_LOG2{1'b0}}};
  localparam logic [C_DEPTH_LOG2:0]   ZERO_LVL = {(C_DEPTH_LOG2+1){1'b0}};
  localparam logic [C_DEPTH_LOG2:0]   ONE_LVL  = {{C_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [C_DEPTH_LOG2-1:0] PTR_ZERO = {C_DEPTH_LOG2{1'b0}};
  localparam logic [C_DEPTH_LOG2-1:0] PTR_ONE  = {{(C_DEPTH_LOG2-1){1'b0}}, 1'b1};

`ifdef DB_IRQ_COALESCE_EN
  localparam logic [15:0] HOLD_INIT = 16'(C_HOLDOFF_CYCLES - 1);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;
  logic [15:0] hold_cnt_r;
  logic [15:0] hold_cnt_s;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;
  // Hold-off length only matters when coalescing is compiled in.
  logic [15:0] unused_holdoff_s;
  assign unused_holdoff_s = 16'(C_HOLDOFF_CYCLES);
`endif

  logic [15:0]             mem_r [DEPTH];
  logic [C_DEPTH_LOG2-1:0] wr_ptr_r;
  logic [C_DEPTH_LOG2-1:0] rd_ptr_r;
  logic [C_DEPTH_LOG2:0]   count_r;
  logic                    overflow_r;
  logic                    irq_req_r;
  state_t                  state_r;
  state_t                  state_s;

  logic full_s;
  logic empty_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign full_s  = (count_r == FULL_LVL);
  assign empty_s = (count_r == ZERO_LVL);
  assign pop_s   = rd_en & ~empty_s;
  // A pop on a full FIFO frees the slot the simultaneous push uses.
  assign push_s  = db_irq & (~full_s | rd_en);
  assign drop_s  = db_irq & full_s & ~rd_en;

  // FIFO storage: written on accepted pushes, deliberately not reset.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= db_info;
    end
  end

  // Pointers, fill level and sticky overflow flag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= ZERO_LVL;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_LVL;
        2'b01:   count_r <= count_r - ONE_LVL;
        default: count_r <= count_r;
      endcase
      // A new drop wins over a coincident clear.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Interrupt FSM next-state logic (and hold-off counter when coalescing).
  always_comb begin
    state_s = state_r;
`ifdef DB_IRQ_COALESCE_EN
    hold_cnt_s = hold_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
`ifdef DB_IRQ_COALESCE_EN
          state_s    = ST_HOLD;
          hold_cnt_s = HOLD_INIT;
`else
          state_s = ST_REQ;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef DB_IRQ_COALESCE_EN
      ST_HOLD: begin
        if (empty_s) begin
          state_s    = ST_IDLE;
          hold_cnt_s = 16'h0000;
        end else if (full_s || (hold_cnt_r == 16'h0000)) begin
          state_s    = ST_REQ;
          hold_cnt_s = 16'h0000;
        end else begin
          state_s    = ST_HOLD;
          hold_cnt_s = hold_cnt_r - 16'h0001;
        end
      end
`endif
      ST_REQ: begin
        // Never retracted without an acknowledge, even if drained meanwhile.
        if (irq_ack) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // Popping the last old entry re-arms, even if a doorbell lands in
        // that same cycle; IDLE then re-raises the request for it.
        if (empty_s || (pop_s && (count_r == ONE_LVL))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Interrupt FSM state and registered request output.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r   <= ST_IDLE;
      irq_req_r <= 1'b0;
`ifdef DB_IRQ_COALESCE_EN
      hold_cnt_r <= 16'h0000;
`endif
    end else begin
      state_r   <= state_s;
      irq_req_r <= (state_s == ST_REQ);
`ifdef DB_IRQ_COALESCE_EN
      hold_cnt_r <= hold_cnt_s;
`endif
    end
  end

  assign irq_req  = irq_req_r;
  assign rd_valid = ~empty_s;
  assign rd_data  = empty_s ? 16'h0000 : mem_r[rd_ptr_r];
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule
